// File: rtl/sn74ls31_delay_meter.sv
// Launches a test edge into an sn74ls31 delay element and measures, in clock
// cycles, how long the (optionally inverted) response takes to follow it.
module sn74ls31_delay_meter #(
    parameter int W      = 8,
    parameter int SETTLE = 4,
    parameter int SYNC   = 2
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         start,
    input  logic         inv,
    input  logic         ack,
    output logic         stim,
    input  logic         resp,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] count,
    output logic         edge_pol,
    output logic         timeout,
    output logic         err
);

    localparam int             SCW         = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE - 1);
    localparam logic [W-1:0]   CNT_MAX     = {W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [SYNC-1:0] r_sync;
    logic [SCW-1:0]  r_settle;
    logic [W-1:0]    r_count;
    logic            r_inv;
    logic            r_stim;
    logic            r_busy;
    logic            r_done;
    logic            r_edge;
    logic            r_timeout;
    logic            r_err;

    logic w_rs;
    logic w_match;

    // The response is asynchronous to clk; only the last stage feeds the FSM.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= resp;
            for (int i = 1; i < SYNC; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_rs    = r_sync[SYNC-1];
    assign w_match = (w_rs == (r_stim ^ r_inv));

    // NOTE: every register below updates with <= so all of them see the
    // pre-edge values of r_stim/r_count; blocking writes would chain them.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state   <= S_IDLE;
            r_settle  <= '0;
            r_count   <= '0;
            r_inv     <= 1'b0;
            r_stim    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_edge    <= 1'b0;
            r_timeout <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_inv     <= inv;
                        r_count   <= '0;
                        r_timeout <= 1'b0;
                        r_err     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_settle  <= '0;
                        r_state   <= S_SETTLE;
                    end
                end

                S_SETTLE: begin
                    if (r_settle == SETTLE_LAST) begin
                        r_count <= '0;
                        if (w_match) begin
                            r_stim  <= ~r_stim;
                            r_edge  <= ~r_stim;
                            r_state <= S_MEASURE;
                        end else begin
                            // Element output was already wrong before launch.
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end

                S_MEASURE: begin
                    // A match on the final count still wins over the timeout.
                    if (w_match) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_count == CNT_MAX) begin
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end

                S_DONE: begin
                    if (ack) begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign stim     = r_stim;
    assign busy     = r_busy;
    assign done     = r_done;
    assign count    = r_count;
    assign edge_pol = r_edge;
    assign timeout  = r_timeout;
    assign err      = r_err;

endmodule
